// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: runs one multiplexed-bus cycle (T1-T2-T3-[TW]-T4) per core request, with HOLD/HLDA bus arbitration.
// Latency: rsp_valid pulses 4 cycles after the req_ready cycle, plus one cycle per wait state (TW).
// Backpressure: req_ready only in IDLE with hold low; at least one IDLE cycle separates consecutive bus cycles.
//
// Optional feature macro: BUS_WAIT_TIMEOUT_EN. When defined, a cycle stuck for 16 consecutive wait
// states is forced to T4 with rsp_err=1 (reads return 16'hFFFF). When undefined, rsp_err is tied to 0.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   req_valid/req_ready       core request handshake (req_ready is combinational, IDLE only)
//   req_we, req_io, req_bhe_n write / IO-space / high-byte-enable qualifiers of the request
//   req_addr, req_wdata       20-bit physical address, 16-bit write data
//   rsp_valid, rsp_rdata      one-cycle completion pulse; last read data (held across writes)
//   rsp_err                   timeout flag, only meaningful with rsp_valid
//   ad_o/ad_oe/ad_i           multiplexed address/data bus (drive, enable, sample)
//   as_o                      A19:16
//   ale, rd_n, wr_n, m_n, bhe_n, den_n, dt   bus strobes and status
//   rdy                       wait control from the addressed device
//   hold/hlda                 external bus request / grant

module bus_cycle_ctrl (
   input  logic        clk,
   input  logic        rst,
   // core request side
   input  logic        req_valid,
   input  logic        req_we,
   input  logic        req_io,
   input  logic        req_bhe_n,
   input  logic [19:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        req_ready,
   // core response side
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   // bus side
   output logic [15:0] ad_o,
   output logic        ad_oe,
   input  logic [15:0] ad_i,
   output logic [3:0]  as_o,
   output logic        ale,
   output logic        rd_n,
   output logic        wr_n,
   output logic        m_n,
   output logic        bhe_n,
   output logic        den_n,
   output logic        dt,
   input  logic        rdy,
   input  logic        hold,
   output logic        hlda
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      T3   = 3'd3,
      TW   = 3'd4,
      T4   = 3'd5,
      HOLD = 3'd6
   } state_t;

   state_t      state;
   logic [15:0] wdata_q;    // write data, driven in T2
   logic        we_q;       // direction of the cycle in flight
   logic        timeout;    // forces T3/TW -> T4 when the wait limit is hit

   // Accept only in IDLE and only while nobody is asking for the bus.
   // Gated by rst so req_ready reads 0 while reset is held.
   assign req_ready = rst && (state == IDLE) && req_valid && !hold;

`ifdef BUS_WAIT_TIMEOUT_EN
   // wait_cnt counts TW cycles already spent with rdy low; the 16th such
   // TW (wait_cnt == 15) ends the cycle with an error instead of waiting on.
   logic [3:0] wait_cnt;
   logic       err_q;

   assign timeout = (state == TW) && !rdy && (wait_cnt == 4'hF);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= 4'd0;
         err_q    <= 1'b0;
      end else begin
         // timeout is only true on the TW->T4 edge, so err_q is high only in T4
         err_q <= timeout;
         if (state == T2)
            wait_cnt <= 4'd0;
         else if ((state == TW) && !rdy)
            wait_cnt <= wait_cnt + 4'd1;
      end
   end

   assign rsp_err = err_q;
`else
   assign timeout = 1'b0;
   assign rsp_err = 1'b0;
`endif

   // State and all bus/response outputs are registered together, so every
   // strobe changes on the edge that enters the corresponding T-state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         wdata_q   <= 16'h0000;
         we_q      <= 1'b0;
         ad_o      <= 16'h0000;
         ad_oe     <= 1'b0;
         as_o      <= 4'h0;
         ale       <= 1'b0;
         rd_n      <= 1'b1;
         wr_n      <= 1'b1;
         den_n     <= 1'b1;
         m_n       <= 1'b1;
         bhe_n     <= 1'b1;
         dt        <= 1'b0;
         hlda      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 16'h0000;
      end else begin
         rsp_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (hold) begin
                  // hold beats a simultaneous request
                  state <= HOLD;
                  hlda  <= 1'b1;
                  ad_oe <= 1'b0;
                  ale   <= 1'b0;
                  rd_n  <= 1'b1;
                  wr_n  <= 1'b1;
                  den_n <= 1'b1;
               end else if (req_valid) begin
                  // Address phase outputs are loaded directly from the request;
                  // ad_o/as_o/bhe_n/m_n/dt then hold the latched cycle attributes.
                  state   <= T1;
                  wdata_q <= req_wdata;
                  we_q    <= req_we;
                  ale     <= 1'b1;
                  ad_oe   <= 1'b1;
                  ad_o    <= req_addr[15:0];
                  as_o    <= req_addr[19:16];
                  bhe_n   <= req_bhe_n;
                  m_n     <= req_io;
                  dt      <= req_we;
               end
            end

            T1: begin
               state <= T2;
               ale   <= 1'b0;
               den_n <= 1'b0;
               if (we_q) begin
                  // write keeps driving the bus, now with data
                  ad_o <= wdata_q;
                  wr_n <= 1'b0;
               end else begin
                  // read turns the bus around for the device
                  ad_oe <= 1'b0;
                  rd_n  <= 1'b0;
               end
            end

            T2: begin
               state <= T3;
            end

            T3, TW: begin
               if (rdy || timeout) begin
                  state     <= T4;
                  rd_n      <= 1'b1;
                  wr_n      <= 1'b1;
                  den_n     <= 1'b1;
                  ad_oe     <= 1'b0;
                  rsp_valid <= 1'b1;
                  // writes leave the last read value untouched
                  if (!we_q)
                     rsp_rdata <= timeout ? 16'hFFFF : ad_i;
               end else begin
                  state <= TW;
               end
            end

            T4: begin
               // always pass through IDLE before the next T1
               state <= IDLE;
            end

            HOLD: begin
               if (!hold) begin
                  state <= IDLE;
                  hlda  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: per-cycle directed vectors for bus_cycle_ctrl plus a long-wait sequence.
// Latency: n/a (bench).
// Backpressure: n/a (bench).

module tb_bus_cycle_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic        req_io = 1'b0;
   logic        req_bhe_n = 1'b1;
   logic [19:0] req_addr = 20'h0;
   logic [15:0] req_wdata = 16'h0;
   logic        req_ready;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic [15:0] ad_o;
   logic        ad_oe;
   logic [15:0] ad_i = 16'h0;
   logic [3:0]  as_o;
   logic        ale, rd_n, wr_n, m_n, bhe_n, den_n, dt;
   logic        rdy = 1'b1;
   logic        hold = 1'b0;
   logic        hlda;

   always #5 clk = ~clk;

   bus_cycle_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_io    (req_io),
      .req_bhe_n (req_bhe_n),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .ad_o      (ad_o),
      .ad_oe     (ad_oe),
      .ad_i      (ad_i),
      .as_o      (as_o),
      .ale       (ale),
      .rd_n      (rd_n),
      .wr_n      (wr_n),
      .m_n       (m_n),
      .bhe_n     (bhe_n),
      .den_n     (den_n),
      .dt        (dt),
      .rdy       (rdy),
      .hold      (hold),
      .hlda      (hlda)
   );

   typedef struct packed {
      logic        rst, vld, we, io, bhe_n;
      logic [19:0] addr;
      logic [15:0] wdata, ad_i;
      logic        rdy, hold;
   } in_t;

   typedef struct packed {
      logic        ready, vld, err;
      logic [15:0] rdata;
      logic        ale, oe;
      logic [15:0] ad_o;
      logic [3:0]  as_o;
      logic        rd_n, wr_n, den_n, dt, m_n, bhe_n, hlda;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
      logic chk;   // 1: also compare as_o/dt/m_n/bhe_n/ad_o (address phase, reset)
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic in_t vi(input logic r, input logic v, input logic we, input logic io,
                              input logic bh, input logic [19:0] a, input logic [15:0] wd,
                              input logic [15:0] di, input logic ry, input logic hd);
      in_t x;
      x.rst = r; x.vld = v; x.we = we; x.io = io; x.bhe_n = bh;
      x.addr = a; x.wdata = wd; x.ad_i = di; x.rdy = ry; x.hold = hd;
      return x;
   endfunction

   function automatic out_t vo(input logic rr, input logic v, input logic [15:0] rd,
                               input logic al, input logic oe, input logic [15:0] ao,
                               input logic [3:0] as, input logic rdn, input logic wrn,
                               input logic denn, input logic t, input logic mn,
                               input logic bh, input logic hl);
      out_t x;
      x.ready = rr; x.vld = v; x.err = 1'b0; x.rdata = rd; x.ale = al; x.oe = oe;
      x.ad_o = ao; x.as_o = as; x.rd_n = rdn; x.wr_n = wrn; x.den_n = denn;
      x.dt = t; x.m_n = mn; x.bhe_n = bh; x.hlda = hl;
      return x;
   endfunction

   function automatic out_t mask(input out_t x, input logic chk, input logic oe_exp);
      out_t y;
      y = x;
      if (!chk) begin
         y.as_o = 4'h0; y.dt = 1'b0; y.m_n = 1'b0; y.bhe_n = 1'b0;
      end
      if (!(chk || oe_exp))
         y.ad_o = 16'h0000;
      return y;
   endfunction

   task automatic add(input in_t i, input out_t o, input logic chk);
      vec_t v;
      v.i = i; v.o = o; v.chk = chk;
      vecs.push_back(v);
   endtask

   task automatic drive(input in_t i);
      rst = i.rst; req_valid = i.vld; req_we = i.we; req_io = i.io; req_bhe_n = i.bhe_n;
      req_addr = i.addr; req_wdata = i.wdata; ad_i = i.ad_i; rdy = i.rdy; hold = i.hold;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   out_t act, e_m, a_m;
   int   lat;
   int   vld_seen;

   initial begin
      // ---- per-cycle table; each row is one clock, outputs are those of that cycle ----
      // vi(rst,vld,we,io,bhe_n,addr,wdata,ad_i,rdy,hold)
      // vo(ready,vld,rdata,ale,oe,ad_o,as_o,rd_n,wr_n,den_n,dt,m_n,bhe_n,hlda)
      add(vi(0,0,0,0,1,20'h0,16'h0,16'h0,1,0),          vo(0,0,16'h0000,0,0,16'h0000,4'h0,1,1,1,0,1,1,0),1); // 0 reset
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,1,0),          vo(0,0,16'h0000,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 1 idle
      add(vi(1,1,0,0,0,20'h12345,16'h0,16'h0,1,0),      vo(1,0,16'h0000,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 2 accept read
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,1,0),          vo(0,0,16'h0000,1,1,16'h2345,4'h1,1,1,1,0,0,0,0),1); // 3 T1
      add(vi(1,0,0,0,1,20'h0,16'h0,16'hBEEF,1,0),       vo(0,0,16'h0000,0,0,16'h0,4'h0,0,1,0,0,0,0,0),0);    // 4 T2
      add(vi(1,0,0,0,1,20'h0,16'h0,16'hBEEF,1,0),       vo(0,0,16'h0000,0,0,16'h0,4'h0,0,1,0,0,0,0,0),0);    // 5 T3
      add(vi(1,0,0,0,1,20'h0,16'h0,16'hBEEF,1,0),       vo(0,1,16'hBEEF,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 6 T4
      add(vi(1,1,1,0,1,20'h00010,16'hA55A,16'h0,1,0),   vo(1,0,16'hBEEF,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 7 accept write
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,0,0),          vo(0,0,16'hBEEF,1,1,16'h0010,4'h0,1,1,1,1,0,1,0),1); // 8 T1
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,0,0),          vo(0,0,16'hBEEF,0,1,16'hA55A,4'h0,1,0,0,0,0,0,0),0); // 9 T2
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,0,0),          vo(0,0,16'hBEEF,0,1,16'hA55A,4'h0,1,0,0,0,0,0,0),0); // 10 T3 rdy=0
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,0,0),          vo(0,0,16'hBEEF,0,1,16'hA55A,4'h0,1,0,0,0,0,0,0),0); // 11 TW1
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,0,0),          vo(0,0,16'hBEEF,0,1,16'hA55A,4'h0,1,0,0,0,0,0,0),0); // 12 TW2
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,1,0),          vo(0,0,16'hBEEF,0,1,16'hA55A,4'h0,1,0,0,0,0,0,0),0); // 13 TW3 rdy=1
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,1,0),          vo(0,1,16'hBEEF,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 14 T4 (+7)
      add(vi(1,1,0,1,0,20'hA5A5A,16'h0,16'h0,1,1),      vo(0,0,16'hBEEF,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 15 hold+req
      add(vi(1,1,0,1,0,20'hA5A5A,16'h0,16'h0,1,1),      vo(0,0,16'hBEEF,0,0,16'h0,4'h0,1,1,1,0,0,0,1),0);    // 16 HOLD
      add(vi(1,1,0,1,0,20'hA5A5A,16'h0,16'h0,1,0),      vo(0,0,16'hBEEF,0,0,16'h0,4'h0,1,1,1,0,0,0,1),0);    // 17 hold drops
      add(vi(1,1,0,1,0,20'hA5A5A,16'h0,16'h1234,1,0),   vo(1,0,16'hBEEF,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 18 IDLE accept IO read
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h1234,1,0),       vo(0,0,16'hBEEF,1,1,16'h5A5A,4'hA,1,1,1,0,1,0,0),1); // 19 T1
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h1234,1,1),       vo(0,0,16'hBEEF,0,0,16'h0,4'h0,0,1,0,0,0,0,0),0);    // 20 T2 hold up
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h1234,1,1),       vo(0,0,16'hBEEF,0,0,16'h0,4'h0,0,1,0,0,0,0,0),0);    // 21 T3
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h1234,1,1),       vo(0,1,16'h1234,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 22 T4
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,1,1),          vo(0,0,16'h1234,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 23 IDLE
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,1,0),          vo(0,0,16'h1234,0,0,16'h0,4'h0,1,1,1,0,0,0,1),0);    // 24 HOLD
      add(vi(1,1,0,0,1,20'h00100,16'h0,16'hDEAD,0,0),   vo(1,0,16'h1234,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 25 accept read
      add(vi(1,0,0,0,1,20'h0,16'h0,16'hDEAD,0,0),       vo(0,0,16'h1234,1,1,16'h0100,4'h0,1,1,1,0,0,1,0),1); // 26 T1
      add(vi(1,0,0,0,1,20'h0,16'h0,16'hDEAD,0,0),       vo(0,0,16'h1234,0,0,16'h0,4'h0,0,1,0,0,0,0,0),0);    // 27 T2
      add(vi(1,0,0,0,1,20'h0,16'h0,16'hDEAD,0,0),       vo(0,0,16'h1234,0,0,16'h0,4'h0,0,1,0,0,0,0,0),0);    // 28 T3
      add(vi(1,0,0,0,1,20'h0,16'h0,16'hDEAD,0,0),       vo(0,0,16'h1234,0,0,16'h0,4'h0,0,1,0,0,0,0,0),0);    // 29 TW
      add(vi(0,0,0,0,1,20'h0,16'h0,16'hDEAD,0,0),       vo(0,0,16'h0000,0,0,16'h0000,4'h0,1,1,1,0,1,1,0),1); // 30 rst mid-TW
      add(vi(0,1,0,0,1,20'h00200,16'h0,16'h0F0F,1,0),   vo(0,0,16'h0000,0,0,16'h0000,4'h0,1,1,1,0,1,1,0),1); // 31 still in reset
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0F0F,1,0),       vo(0,0,16'h0000,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 32 released
      add(vi(1,1,0,0,1,20'h00200,16'h0,16'h0F0F,1,0),   vo(1,0,16'h0000,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 33 accept read
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0F0F,1,0),       vo(0,0,16'h0000,1,1,16'h0200,4'h0,1,1,1,0,0,1,0),1); // 34 T1
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0F0F,1,0),       vo(0,0,16'h0000,0,0,16'h0,4'h0,0,1,0,0,0,0,0),0);    // 35 T2
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0F0F,1,0),       vo(0,0,16'h0000,0,0,16'h0,4'h0,0,1,0,0,0,0,0),0);    // 36 T3
      add(vi(1,1,1,0,1,20'h00300,16'h1111,16'h0F0F,1,0),vo(0,1,16'h0F0F,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 37 T4, req waits
      add(vi(1,1,1,0,1,20'h00300,16'h1111,16'h0F0F,1,0),vo(1,0,16'h0F0F,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 38 IDLE accept
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,1,0),          vo(0,0,16'h0F0F,1,1,16'h0300,4'h0,1,1,1,1,0,1,0),1); // 39 T1
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,1,0),          vo(0,0,16'h0F0F,0,1,16'h1111,4'h0,1,0,0,0,0,0,0),0); // 40 T2
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,1,0),          vo(0,0,16'h0F0F,0,1,16'h1111,4'h0,1,0,0,0,0,0,0),0); // 41 T3
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,1,0),          vo(0,1,16'h0F0F,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 42 T4
      add(vi(1,0,0,0,1,20'h0,16'h0,16'h0,1,0),          vo(0,0,16'h0F0F,0,0,16'h0,4'h0,1,1,1,0,0,0,0),0);    // 43 IDLE

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         drive(vecs[k].i);
         #1;
         act = '{ready:req_ready, vld:rsp_valid, err:rsp_err, rdata:rsp_rdata, ale:ale,
                 oe:ad_oe, ad_o:ad_o, as_o:as_o, rd_n:rd_n, wr_n:wr_n, den_n:den_n,
                 dt:dt, m_n:m_n, bhe_n:bhe_n, hlda:hlda};
         a_m = mask(act, vecs[k].chk, vecs[k].o.oe);
         e_m = mask(vecs[k].o, vecs[k].chk, vecs[k].o.oe);
         n_vec++;
         if (a_m !== e_m) begin
            n_bad++;
            $display("FAIL vec%0d: got %h, expected %h", k, a_m, e_m);
         end
      end

      // ---- long wait: rdy held low well past 16 wait states ----
      @(negedge clk);
      rst = 1'b1; hold = 1'b0; rdy = 1'b0; ad_i = 16'h7777;
      req_valid = 1'b1; req_we = 1'b0; req_io = 1'b0; req_bhe_n = 1'b0; req_addr = 20'h00400;
      #1 check("long_accept", {31'd0, req_ready}, 32'd1);
      lat = 0;
      vld_seen = 0;
`ifdef BUS_WAIT_TIMEOUT_EN
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         req_valid = 1'b0;
         #1;
         if (rsp_valid && lat == 0) begin
            lat = n;
            check("timeout_err", {31'd0, rsp_err}, 32'd1);
            check("timeout_rdata", {16'd0, rsp_rdata}, 32'h0000FFFF);
            break;
         end
      end
      check("timeout_latency", lat, 32'd20);
      @(negedge clk);
      #1 check("timeout_err_clears", {30'd0, rsp_valid, rsp_err}, 32'd0);
`else
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         req_valid = 1'b0;
         #1;
         if (rsp_valid || rsp_err) vld_seen++;
      end
      check("no_timeout_vld", vld_seen, 32'd0);
      check("still_wait_rd_n", {31'd0, rd_n}, 32'd0);
      rdy = 1'b1;
      @(negedge clk);
      #1;
      check("wait_release_vld", {31'd0, rsp_valid}, 32'd1);
      check("wait_release_rdata", {16'd0, rsp_rdata}, 32'h00007777);
      check("wait_release_err", {31'd0, rsp_err}, 32'd0);
`endif
      rdy = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
